// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt pending controller: channel count,
// channel-index width, service FSM states and a one-hot channel helper.
package irq_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = $clog2(NUM_CH);

    typedef enum logic {
        IDLE   = 1'b0,
        ASSERT = 1'b1
    } state_t;

    typedef logic [CH_W-1:0] ch_idx_t;

    function automatic logic [NUM_CH-1:0] ch_onehot(input ch_idx_t idx);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector for the request lines: registers irq_in, flags 0->1 transitions.
// Latency: combinational edge vector, valid in the cycle the level first appears.
// Backpressure: none; every edge is reported once.
module irq_edge_detect #(
    parameter int NUM_CH = irq_pkg::NUM_CH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] irq_in,
    output logic [NUM_CH-1:0] rise
);

    logic [NUM_CH-1:0] irq_prev;

    // Clearing irq_prev in reset makes a level held through release look like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev <= '0;
        end else begin
            irq_prev <= irq_in;
        end
    end

    assign rise = irq_in & ~irq_prev;

endmodule

// File: rtl/priority_encoder_4to2.sv
// Fixed-priority 4-to-2 encoder, bit 3 highest; valid when any request is set.
// Latency: purely combinational.
// Backpressure: none.
module priority_encoder_4to2 (
    input  logic [3:0] req,
    output logic [1:0] code,
    output logic       valid
);

    always_comb begin
        code  = 2'd0;
        valid = |req;
        if (req[3]) begin
            code = 2'd3;
        end else if (req[2]) begin
            code = 2'd2;
        end else if (req[1]) begin
            code = 2'd1;
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Edge-triggered interrupt pending controller with external priority encoder loop.
// Latency: edge in N -> pend_req in N+1 -> irq_out in N+2; one IDLE cycle between services.
// Backpressure: irq_out/irq_id held until irq_ack; repeat edges on a pending channel set overflow.
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_CH = irq_pkg::NUM_CH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] irq_in,
    input  logic [NUM_CH-1:0] mask,
    output logic [NUM_CH-1:0] pend_req,
    input  logic [CH_W-1:0]   enc_code,
    input  logic              enc_valid,
    output logic              irq_out,
    output logic [CH_W-1:0]   irq_id,
    input  logic              irq_ack,
    output logic [NUM_CH-1:0] overflow,
    input  logic              ovf_clr
);

    state_t            state;
    state_t            state_nxt;
    logic              id_load;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] pending_nxt;
    logic [NUM_CH-1:0] clr_vec;
    logic [NUM_CH-1:0] ovf_evt;
    logic [NUM_CH-1:0] overflow_nxt;

    irq_edge_detect #(
        .NUM_CH (NUM_CH)
    ) u_edge (
        .clk    (clk),
        .rst    (rst),
        .irq_in (irq_in),
        .rise   (rise)
    );

    // A new edge beats the ack-clear on the same channel, and only counts as
    // lost when the channel was already pending and is not being retired now.
    always_comb begin
        clr_vec      = '0;
        if ((state == ASSERT) && irq_ack) begin
            clr_vec = ch_onehot(irq_id);
        end
        ovf_evt      = rise & pending & ~clr_vec;
        pending_nxt  = (pending & ~clr_vec) | rise;
        overflow_nxt = (ovf_clr ? '0 : overflow) | ovf_evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            overflow <= '0;
        end else begin
            pending  <= pending_nxt;
            overflow <= overflow_nxt;
        end
    end

    assign pend_req = pending & ~mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Mask changes only affect the encoder input, so an active service is never disturbed.
    always_comb begin
        state_nxt = state;
        id_load   = 1'b0;
        case (state)
            IDLE: begin
                if (enc_valid) begin
                    state_nxt = ASSERT;
                    id_load   = 1'b1;
                end
            end
            ASSERT: begin
                if (irq_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_id  <= '0;
            irq_out <= 1'b0;
        end else begin
            if (id_load) begin
                irq_id <= enc_code;
            end
            irq_out <= (state_nxt == ASSERT);
        end
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Randomised scoreboard bench for irq_pending_ctrl with the 4-to-2 encoder in the loop.
module tb_irq_pending_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_in;
    logic [3:0] mask;
    logic [3:0] pend_req;
    logic [1:0] enc_code;
    logic       enc_valid;
    logic       irq_out;
    logic [1:0] irq_id;
    logic       irq_ack;
    logic [3:0] overflow;
    logic       ovf_clr;

    always #5 clk = ~clk;

    irq_pending_ctrl #(.NUM_CH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .mask      (mask),
        .pend_req  (pend_req),
        .enc_code  (enc_code),
        .enc_valid (enc_valid),
        .irq_out   (irq_out),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    priority_encoder_4to2 u_enc (
        .req   (pend_req),
        .code  (enc_code),
        .valid (enc_valid)
    );

    typedef struct packed {
        logic [3:0] pend_req;
        logic       irq_out;
        logic [1:0] irq_id;
        logic [3:0] overflow;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: per-channel pending/lost flags plus "who is being serviced".
    bit m_pend [4];
    bit m_ovf  [4];
    bit m_prev [4];
    bit m_busy;
    int m_id;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 1'b0;
            m_ovf[i]  = 1'b0;
            m_prev[i] = 1'b0;
        end
        m_busy = 1'b0;
        m_id   = 0;
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.pend_req[i] = m_pend[i] & ~mask[i];
            e.overflow[i] = m_ovf[i];
        end
        e.irq_out = m_busy;
        e.irq_id  = 2'(m_id);
        return e;
    endfunction

    function automatic void model_advance();
        int sel;
        bit cleared;
        bit rise;
        sel = -1;
        if (!m_busy) begin
            for (int i = 0; i < 4; i++) begin
                if (m_pend[i] && !mask[i]) sel = i;
            end
        end
        for (int i = 0; i < 4; i++) begin
            cleared   = m_busy && irq_ack && (m_id == i);
            rise      = irq_in[i] && !m_prev[i];
            m_ovf[i]  = (m_ovf[i] && !ovf_clr) || (rise && m_pend[i] && !cleared);
            if (rise) m_pend[i] = 1'b1;
            else if (cleared) m_pend[i] = 1'b0;
            m_prev[i] = irq_in[i];
        end
        if (!m_busy) begin
            if (sel >= 0) begin
                m_busy = 1'b1;
                m_id   = sel;
            end
        end else if (irq_ack) begin
            m_busy = 1'b0;
        end
    endfunction

    task automatic step();
        exp_q.push_back(model_outputs());
        model_advance();
    endtask

    task automatic cycle(input logic [3:0] i, input logic [3:0] m, input logic a, input logic c);
        @(posedge clk);
        #1;
        irq_in  = i;
        mask    = m;
        irq_ack = a;
        ovf_clr = c;
        step();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
    endtask

    task automatic mid_reset(input logic [3:0] hold);
        @(posedge clk);
        #3;
        irq_in  = hold;
        irq_ack = 1'b0;
        ovf_clr = 1'b0;
        rst     = 1'b1;
        #1;
        check("rst_irq_out", irq_out, 0);
        check("rst_pend_req", pend_req, 0);
        check("rst_overflow", overflow, 0);
        model_reset();
        release_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pend_req", pend_req, e.pend_req);
                check("irq_out", irq_out, e.irq_out);
                check("irq_id", irq_id, e.irq_id);
                check("overflow", overflow, e.overflow);
            end
        end
    end

    initial begin : watchdog
        #400000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : stim
        logic [3:0] ir;
        logic [3:0] mk;
        rst     = 1'b1;
        irq_in  = '0;
        mask    = '0;
        irq_ack = 1'b0;
        ovf_clr = 1'b0;
        #2;
        check("reset_irq_out", irq_out, 0);
        check("reset_irq_id", irq_id, 0);
        check("reset_pend_req", pend_req, 0);
        check("reset_overflow", overflow, 0);
        model_reset();
        release_reset();

        // Single event
        cycle(4'b0001, 4'b0000, 0, 0);
        cycle(4'b0000, 4'b0000, 0, 0);
        check("single_pend_req", pend_req, 4'b0001);
        cycle(4'b0000, 4'b0000, 0, 0);
        check("single_irq_out", irq_out, 1);
        check("single_irq_id", irq_id, 0);
        cycle(4'b0000, 4'b0000, 1, 0);
        cycle(4'b0000, 4'b0000, 0, 0);
        check("single_cleared", pend_req, 4'b0000);

        // Priority between two simultaneous edges
        cycle(4'b0101, 4'b0000, 0, 0);
        cycle(4'b0000, 4'b0000, 0, 0);
        cycle(4'b0000, 4'b0000, 0, 0);
        check("prio_first_id", irq_id, 2);
        cycle(4'b0000, 4'b0000, 1, 0);
        cycle(4'b0000, 4'b0000, 0, 0);
        check("prio_idle_gap", irq_out, 0);
        cycle(4'b0000, 4'b0000, 0, 0);
        check("prio_second_out", irq_out, 1);
        check("prio_second_id", irq_id, 0);
        cycle(4'b0000, 4'b0000, 1, 0);

        // Masked channel waits until unmasked
        cycle(4'b1000, 4'b1000, 0, 0);
        cycle(4'b0000, 4'b1000, 0, 0);
        cycle(4'b0000, 4'b1000, 0, 0);
        check("mask_no_irq", irq_out, 0);
        check("mask_no_req", pend_req, 4'b0000);
        cycle(4'b0000, 4'b0000, 0, 0);
        cycle(4'b0000, 4'b0000, 0, 0);
        check("unmask_irq_id", irq_id, 3);
        check("unmask_irq_out", irq_out, 1);
        cycle(4'b0000, 4'b0000, 1, 0);

        // Overflow, clear, and clear racing a new loss
        cycle(4'b0010, 4'b0000, 0, 0);
        cycle(4'b0000, 4'b0000, 0, 0);
        cycle(4'b0010, 4'b0000, 0, 0);
        cycle(4'b0000, 4'b0000, 0, 0);
        check("ovf_set", overflow, 4'b0010);
        cycle(4'b0000, 4'b0000, 0, 1);
        cycle(4'b0000, 4'b0000, 0, 0);
        check("ovf_clr", overflow, 4'b0000);
        cycle(4'b0010, 4'b0000, 0, 1);
        cycle(4'b0000, 4'b0000, 0, 0);
        check("ovf_clr_race", overflow, 4'b0010);
        cycle(4'b0000, 4'b0000, 1, 1);
        cycle(4'b0000, 4'b0000, 0, 0);

        // Edge coincident with ack on the serviced channel
        cycle(4'b0100, 4'b0000, 0, 0);
        cycle(4'b0000, 4'b0000, 0, 0);
        cycle(4'b0000, 4'b0000, 0, 0);
        check("race_setup_id", irq_id, 2);
        cycle(4'b0100, 4'b0000, 1, 0);
        cycle(4'b0000, 4'b0000, 0, 0);
        check("race_pend_kept", pend_req[2], 1);
        check("race_no_ovf", overflow[2], 0);
        cycle(4'b0000, 4'b0000, 0, 0);
        check("race_reassert", irq_out, 1);
        cycle(4'b0000, 4'b0000, 1, 0);

        // Reset during service with a level held through release
        cycle(4'b0001, 4'b0000, 0, 0);
        cycle(4'b0000, 4'b0000, 0, 0);
        cycle(4'b0000, 4'b0000, 0, 0);
        mid_reset(4'b0001);
        cycle(4'b0001, 4'b0000, 0, 0);
        check("rst_recapture", pend_req, 4'b0001);

        // Randomised traffic
        ir = '0;
        mk = '0;
        for (int n = 0; n < 3000; n++) begin
            ir = ir ^ (4'($urandom) & 4'($urandom));
            if ($urandom_range(0, 15) == 0) mk = 4'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                mid_reset(ir);
            end else begin
                cycle(ir, mk, ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
            end
        end

        cycle(4'b0000, 4'b0000, 0, 0);
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
